// File: rtl/icc_branch_unit.sv
// Integer condition-code register and SPARC V8 Bicc resolver with delay-slot/annul tracking.
// Optional build macro ICC_BYPASS_EN: branch evaluation forwards same-cycle ALU flags.
module icc_branch_unit #(
  parameter int ADDR_W = 32,
  parameter int DISP_W = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cc_we,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              v_in,
  input  logic              c_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic              br_annul,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [DISP_W-1:0] br_disp,
  input  logic              slot_fire,
  output logic              res_valid,
  output logic              taken,
  output logic [ADDR_W-1:0] target,
  output logic              slot_kill,
  output logic [3:0]        icc,
  output logic              carry_out
);

  typedef enum logic {IDLE, SLOT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        icc_q, icc_d;
  logic              res_valid_q, res_valid_d;
  logic              taken_q, taken_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              slot_kill_q, slot_kill_d;

  logic [3:0]        flags_in;
  logic [3:0]        eval_cc;
  logic              cond_true;
  logic              accept;
  logic [ADDR_W-1:0] disp_ext;
  logic [ADDR_W-1:0] br_tgt;

  // Upper half of the cond space is the bitwise negation of the lower half.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzvc);
    logic n, z, v, c, base;
    {n, z, v, c} = nzvc;
    case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      default: base = v;
    endcase
    return base ^ cond[3];
  endfunction

  assign flags_in = {n_in, z_in, v_in, c_in};

`ifdef ICC_BYPASS_EN
  assign eval_cc  = cc_we ? flags_in : icc_q;
  assign br_ready = (state_q == IDLE);
`else
  // Without forwarding, hold the branch off until the flag write has landed.
  assign eval_cc  = icc_q;
  assign br_ready = (state_q == IDLE) & ~cc_we;
`endif

  assign cond_true = cond_eval(br_cond, eval_cc);
  assign accept    = br_valid & br_ready;
  assign disp_ext  = {{(ADDR_W-DISP_W){br_disp[DISP_W-1]}}, br_disp};
  assign br_tgt    = br_pc + (disp_ext << 2);

  always_comb begin
    state_d     = state_q;
    icc_d       = cc_we ? flags_in : icc_q;
    res_valid_d = 1'b0;
    taken_d     = taken_q;
    target_d    = target_q;
    slot_kill_d = slot_kill_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          taken_d     = cond_true;
          target_d    = br_tgt;
          // BA,a annuls its slot even though it is taken.
          slot_kill_d = br_annul & (~cond_true | (br_cond == 4'h8));
          res_valid_d = 1'b1;
          state_d     = SLOT;
        end
      end
      SLOT: begin
        if (slot_fire) begin
          state_d     = IDLE;
          slot_kill_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      icc_q       <= '0;
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      slot_kill_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      icc_q       <= icc_d;
      res_valid_q <= res_valid_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      slot_kill_q <= slot_kill_d;
    end
  end

  assign res_valid = res_valid_q;
  assign taken     = taken_q;
  assign target    = target_q;
  assign slot_kill = slot_kill_q;
  assign icc       = icc_q;
  assign carry_out = icc_q[0];

endmodule

// File: tb/tb_icc_branch_unit.sv
// Randomized self-checking bench for icc_branch_unit against a behavioural Bicc model.
module tb_icc_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cc_we = 1'b0, n_in = 1'b0, z_in = 1'b0, v_in = 1'b0, c_in = 1'b0;
  logic        br_valid = 1'b0, br_ready;
  logic [3:0]  br_cond = '0;
  logic        br_annul = 1'b0;
  logic [31:0] br_pc = '0;
  logic [21:0] br_disp = '0;
  logic        slot_fire = 1'b0;
  logic        res_valid, taken, slot_kill, carry_out;
  logic [31:0] target;
  logic [3:0]  icc;

  int checks = 0;
  int errors = 0;
  logic [3:0] mdl_icc = '0;

  icc_branch_unit #(.ADDR_W(32), .DISP_W(22)) dut (
    .clk(clk), .rst_n(rst_n), .cc_we(cc_we), .n_in(n_in), .z_in(z_in), .v_in(v_in), .c_in(c_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_annul(br_annul),
    .br_pc(br_pc), .br_disp(br_disp), .slot_fire(slot_fire), .res_valid(res_valid),
    .taken(taken), .target(target), .slot_kill(slot_kill), .icc(icc), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bicc semantics written as the architectural relations they implement.
  function automatic logic mdl_taken(input int cond, input logic [3:0] f);
    bit n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond)
      0:  return 0;                    // BN
      1:  return z;                    // BE
      2:  return z || (n != v);        // BLE
      3:  return n != v;               // BL
      4:  return c || z;               // BLEU
      5:  return c;                    // BCS
      6:  return n;                    // BNEG
      7:  return v;                    // BVS
      8:  return 1;                    // BA
      9:  return !z;                   // BNE
      10: return !z && (n == v);       // BG
      11: return n == v;               // BGE
      12: return !c && !z;             // BGU
      13: return !c;                   // BCC
      14: return !n;                   // BPOS
      default: return !v;              // BVC
    endcase
  endfunction

  function automatic logic [31:0] mdl_target(input logic [31:0] pc, input logic [21:0] disp);
    longint d, t;
    d = longint'(disp);
    if (d >= 64'd2097152) d = d - 64'd4194304;
    t = longint'(pc) + d * 4;
    return t[31:0];
  endfunction

  task automatic set_cc(input logic [3:0] f);
    cc_we = 1'b1; {n_in, z_in, v_in, c_in} = f;
    tick();
    cc_we = 1'b0;
    mdl_icc = f;
  endtask

  // Present a branch in IDLE and step through the accept edge.
  task automatic issue(input int cond, input logic a, input logic [31:0] pc, input logic [21:0] disp);
    br_valid = 1'b1; br_cond = 4'(cond); br_annul = a; br_pc = pc; br_disp = disp;
    tick();
    br_valid = 1'b0;
  endtask

  task automatic retire();
    slot_fire = 1'b1;
    tick();
    slot_fire = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if ({res_valid, taken, slot_kill, target, icc} !== 39'd0) begin errors++;
      $display("FAIL reset_outputs got rv=%b tk=%b sk=%b tgt=%h icc=%h want all 0", res_valid, taken, slot_kill, target, icc); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", br_ready); end
  endtask

  task automatic test_be_taken();
    set_cc(4'b0100);
    checks++; if (icc !== 4'b0100) begin errors++; $display("FAIL icc_load got %b want 0100", icc); end
    issue(1, 1'b0, 32'h100, 22'd4);
    checks++; if ({res_valid, taken, slot_kill} !== 3'b110 || target !== 32'h110) begin errors++;
      $display("FAIL be_taken got rv=%b tk=%b sk=%b tgt=%h want 1 1 0 00000110", res_valid, taken, slot_kill, target); end
    tick();
    checks++; if (res_valid !== 1'b0 || taken !== 1'b1 || target !== 32'h110) begin errors++;
      $display("FAIL be_hold got rv=%b tk=%b tgt=%h want 0 1 00000110", res_valid, taken, target); end
    retire();
  endtask

  task automatic test_annul();
    set_cc(4'b0000);
    issue(1, 1'b1, 32'h200, 22'd8);
    checks++; if ({taken, slot_kill, br_ready} !== 3'b010) begin errors++;
      $display("FAIL annul got tk=%b sk=%b rdy=%b want 0 1 0", taken, slot_kill, br_ready); end
    tick();
    checks++; if ({slot_kill, br_ready} !== 2'b10) begin errors++;
      $display("FAIL annul_hold got sk=%b rdy=%b want 1 0", slot_kill, br_ready); end
    retire();
    checks++; if ({slot_kill, br_ready} !== 2'b01) begin errors++;
      $display("FAIL annul_retire got sk=%b rdy=%b want 0 1", slot_kill, br_ready); end
  endtask

  task automatic test_ba_wrap();
    issue(8, 1'b1, 32'h100, 22'h3FFFFF);
    checks++; if ({taken, slot_kill} !== 2'b11 || target !== 32'h0FC) begin errors++;
      $display("FAIL ba_annul got tk=%b sk=%b tgt=%h want 1 1 000000fc", taken, slot_kill, target); end
    retire();
    issue(8, 1'b0, 32'hFFFFFFFC, 22'd1);
    checks++; if (target !== 32'h0 || slot_kill !== 1'b0) begin errors++;
      $display("FAIL target_wrap got tgt=%h sk=%b want 00000000 0", target, slot_kill); end
    retire();
  endtask

  task automatic test_cond_pairs();
    int conds [6] = '{3, 11, 10, 4, 12, 7};
    logic [3:0] ccs [6] = '{4'b1000, 4'b1000, 4'b0000, 4'b0011, 4'b0011, 4'b0011};
    logic exp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      set_cc(ccs[i]);
      issue(conds[i], 1'b0, 32'h1000, 22'd2);
      checks++; if (taken !== exp[i]) begin errors++;
        $display("FAIL cond_pair cond=%0d nzvc=%b got %b want %b", conds[i], ccs[i], taken, exp[i]); end
      retire();
    end
  endtask

  task automatic test_random_sweep();
    logic [3:0] f;
    logic [31:0] pc;
    logic [21:0] disp;
    logic a, et, ek;
    for (int i = 0; i < 64; i++) begin
      f = 4'($urandom_range(0, 15));
      pc = {$urandom, 2'b00} ;
      disp = 22'($urandom);
      a = 1'($urandom);
      set_cc(f);
      // First 16 iterations walk every cond; the rest are random.
      issue((i < 16) ? i : int'($urandom_range(0, 15)), a, pc, disp);
      et = mdl_taken(int'(br_cond), mdl_icc);
      ek = a && (!et || br_cond == 4'd8);
      checks++; if (res_valid !== 1'b1 || taken !== et || slot_kill !== ek || target !== mdl_target(pc, disp)) begin errors++;
        $display("FAIL sweep cond=%0d nzvc=%b a=%b got rv=%b tk=%b sk=%b tgt=%h want 1 %b %b %h",
                 br_cond, f, a, res_valid, taken, slot_kill, target, et, ek, mdl_target(pc, disp)); end
      retire();
    end
  endtask

  task automatic test_back_to_back();
    set_cc(4'b0100);
    issue(1, 1'b0, 32'h40, 22'd1);
    br_valid = 1'b1;
    tick(); tick();
    checks++; if (res_valid !== 1'b0 || br_ready !== 1'b0) begin errors++;
      $display("FAIL dcti_stall got rv=%b rdy=%b want 0 0", res_valid, br_ready); end
    slot_fire = 1'b1;
    tick();
    slot_fire = 1'b0;
    checks++; if (res_valid !== 1'b0 || br_ready !== 1'b1) begin errors++;
      $display("FAIL dcti_idle got rv=%b rdy=%b want 0 1", res_valid, br_ready); end
    br_cond = 4'd9; br_pc = 32'h80; br_disp = 22'd3;
    tick();
    br_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || taken !== 1'b0 || target !== 32'h8C) begin errors++;
      $display("FAIL dcti_accept got rv=%b tk=%b tgt=%h want 1 0 0000008c", res_valid, taken, target); end
    retire();
    slot_fire = 1'b1;
    tick();
    slot_fire = 1'b0;
    checks++; if (res_valid !== 1'b0 || br_ready !== 1'b1) begin errors++;
      $display("FAIL slot_fire_idle got rv=%b rdy=%b want 0 1", res_valid, br_ready); end
  endtask

  task automatic test_bypass();
    set_cc(4'b0000);
    cc_we = 1'b1; {n_in, z_in, v_in, c_in} = 4'b0100;
    br_valid = 1'b1; br_cond = 4'd1; br_annul = 1'b0; br_pc = 32'h300; br_disp = 22'd1;
`ifdef ICC_BYPASS_EN
    #1;
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got %b want 1", br_ready); end
    tick();
    cc_we = 1'b0; br_valid = 1'b0;
`else
    #1;
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL bypass_stall got %b want 0", br_ready); end
    tick();
    cc_we = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bypass_noaccept got rv=%b want 0", res_valid); end
    tick();
    br_valid = 1'b0;
`endif
    mdl_icc = 4'b0100;
    checks++; if (res_valid !== 1'b1 || taken !== 1'b1) begin errors++;
      $display("FAIL bypass_taken got rv=%b tk=%b want 1 1", res_valid, taken); end
    retire();
  endtask

  task automatic test_carry_reset();
    set_cc(4'b0001);
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL carry_out got %b want 1", carry_out); end
    issue(0, 1'b1, 32'h500, 22'd5);
    rst_n = 1'b0;
    #1;
    checks++; if ({res_valid, taken, slot_kill, target, icc, carry_out} !== 40'd0) begin errors++;
      $display("FAIL midslot_reset got rv=%b tk=%b sk=%b tgt=%h icc=%h co=%b want all 0", res_valid, taken, slot_kill, target, icc, carry_out); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", br_ready); end
  endtask

  initial begin
    test_reset();
    test_be_taken();
    test_annul();
    test_ba_wrap();
    test_cond_pairs();
    test_random_sweep();
    test_back_to_back();
    test_bypass();
    test_carry_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
